// File: rtl/cap_buf_pkg.sv
// Shared types and register map for the multi-channel capture buffer.
// Latency: n/a (types, constants and one combinational helper).
// Backpressure: n/a.
package cap_buf_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ARMED   = 2'd1,
        CAPTURE = 2'd2,
        SWAP    = 2'd3
    } cap_state_e;

    typedef enum logic [1:0] {
        EDGE_RISE = 2'd0,
        EDGE_FALL = 2'd1,
        EDGE_BOTH = 2'd2,
        EDGE_RSVD = 2'd3
    } edge_mode_e;

    // Register offsets inside the register space (address MSB = 1)
    localparam int REG_STATUS = 0;
    localparam int REG_CTRL   = 1;
    localparam int REG_TS_LO  = 2;
    localparam int REG_TS_HI  = 3;

    // STATUS bit positions
    localparam int ST_STATE_LSB   = 0;
    localparam int ST_LOCK_BIT    = 2;
    localparam int ST_OVERRUN_BIT = 3;
    localparam int ST_READY_BIT   = 4;

    // CTRL bit positions
    localparam int CTRL_LOCK_BIT    = 0;
    localparam int CTRL_ARM_BIT     = 1;
    localparam int CTRL_EDGE_LSB    = 2;
    localparam int CTRL_CLR_OVR_BIT = 4;

    // Edge detect on the previous/current comparator level; the reserved mode never fires
    function automatic logic edge_hit(input edge_mode_e mode, input logic prev, input logic cur);
        case (mode)
            EDGE_RISE: return cur & ~prev;
            EDGE_FALL: return ~cur & prev;
            EDGE_BOTH: return cur ^ prev;
            default:   return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/cap_bank_ram.sv
// Two-bank sample store for one channel: one write port, one registered read port; bank = addr MSB.
// Latency: read data appears one clock after the read address is presented.
// Backpressure: none; writes and reads are accepted every cycle.
module cap_bank_ram #(
    parameter int DATA_WIDTH = 12,
    parameter int DEPTH      = 1024,
    localparam int AW        = 1 + $clog2(DEPTH)
) (
    input  logic                  i_clk,
    input  logic                  i_we,
    input  logic [AW-1:0]         i_waddr,
    input  logic [DATA_WIDTH-1:0] i_wdata,
    input  logic [AW-1:0]         i_raddr,
    output logic [DATA_WIDTH-1:0] o_rdata
);

    logic [DATA_WIDTH-1:0] r_mem [0:2*DEPTH-1];
    logic [DATA_WIDTH-1:0] r_rdata;

    // Sample write port
    always_ff @(posedge i_clk) begin
        if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
    end

    // Registered read port (contents are never reset)
    always_ff @(posedge i_clk) begin
        r_rdata <= r_mem[i_raddr];
    end

    assign o_rdata = r_rdata;

endmodule

// File: rtl/multi_ch_capture_buffer.sv
// Triggered NUM_CH-channel ping-pong capture with host bus access; CAP_TIMESTAMP_EN adds trigger timestamps.
// Latency: bus read data/rvalid two clocks after bus_rd; trigger sample is written in its own sample_en cycle.
// Backpressure: none; samples arriving while a bank swap is held by lock are dropped and flag overrun.
module multi_ch_capture_buffer
    import cap_buf_pkg::*;
#(
    parameter int DATA_WIDTH = 12,
    parameter int BUS_WIDTH  = 16,
    parameter int DEPTH      = 1024,
    parameter int NUM_CH     = 2,
    localparam int ADDR_W    = 1 + $clog2(NUM_CH) + $clog2(DEPTH)
) (
    input  logic                         i_clk,
    input  logic                         i_rst_n,
    input  logic                         i_sample_en,
    input  logic [NUM_CH*DATA_WIDTH-1:0] i_sample_data,
    input  logic                         i_stable,
    input  logic                         i_trig_in,
    input  logic [ADDR_W-1:0]            i_bus_addr,
    input  logic                         i_bus_wr,
    input  logic                         i_bus_rd,
    input  logic [BUS_WIDTH-1:0]         i_bus_wdata,
    output logic [BUS_WIDTH-1:0]         o_bus_rdata,
    output logic                         o_bus_rvalid,
    output logic                         o_ready,
    output logic                         o_capturing
);

    localparam int IDX_W  = $clog2(DEPTH);
    localparam int CH_W   = $clog2(NUM_CH);
    localparam int CHS_W  = (CH_W > 0) ? CH_W : 1;
    localparam int RAM_AW = 1 + IDX_W;
    localparam int OFF_W  = ADDR_W - 1;

    cap_state_e            r_state, w_state_nxt;
    edge_mode_e            r_edge;
    logic                  r_write_bank, r_ready, r_overrun, r_lock, r_arm, r_trig_prev;
    logic [IDX_W-1:0]      r_ptr;
    logic                  r_rd_vld1, r_rd_is_reg1;
    logic [CHS_W-1:0]      r_rd_ch1;
    logic [BUS_WIDTH-1:0]  r_reg_dat1, r_bus_rdata;
    logic                  r_bus_rvalid;

    logic                  w_is_reg, w_ctrl_wr, w_rd_take, w_arm_clr, w_lock_rise;
    logic                  w_trigger, w_cap_write, w_ram_we, w_swap_done;
    logic [OFF_W-1:0]      w_reg_off;
    logic [IDX_W-1:0]      w_wr_idx, w_rd_idx;
    logic [CHS_W-1:0]      w_rd_ch;
    logic [BUS_WIDTH-1:0]  w_reg_rdata;
    logic [DATA_WIDTH-1:0] w_ram_q [NUM_CH];
    logic                  w_unused_wdata;

    assign w_is_reg    = i_bus_addr[ADDR_W-1];
    assign w_reg_off   = i_bus_addr[OFF_W-1:0];
    assign w_rd_idx    = i_bus_addr[IDX_W-1:0];
    assign w_ctrl_wr   = i_bus_wr & w_is_reg & (w_reg_off == OFF_W'(REG_CTRL));
    // A write in the same cycle wins over a read
    assign w_rd_take   = i_bus_rd & ~i_bus_wr;
    assign w_arm_clr   = w_ctrl_wr & ~i_bus_wdata[CTRL_ARM_BIT];
    assign w_lock_rise = w_ctrl_wr & i_bus_wdata[CTRL_LOCK_BIT] & ~r_lock;
    assign w_trigger   = (r_state == ARMED) & i_sample_en & i_stable & ~r_lock
                         & edge_hit(r_edge, r_trig_prev, i_trig_in);
    assign w_cap_write = (r_state == CAPTURE) & i_sample_en & i_stable;
    assign w_ram_we    = w_trigger | w_cap_write;
    assign w_wr_idx    = w_trigger ? '0 : r_ptr;
    // A lock rising in the completion cycle blocks the swap
    assign w_swap_done = (r_state == SWAP) & ~r_lock & ~w_lock_rise & ~w_arm_clr;
    assign w_unused_wdata = ^i_bus_wdata[BUS_WIDTH-1:5];

    generate
        if (CH_W > 0) begin : g_ch_sel
            assign w_rd_ch = i_bus_addr[IDX_W +: CH_W];
        end else begin : g_one_ch
            assign w_rd_ch = '0;
        end
        for (genvar c = 0; c < NUM_CH; c++) begin : g_ram
            cap_bank_ram #(.DATA_WIDTH(DATA_WIDTH), .DEPTH(DEPTH)) u_ram (
                .i_clk   (i_clk),
                .i_we    (w_ram_we),
                .i_waddr ({r_write_bank, w_wr_idx}),
                .i_wdata (i_sample_data[c*DATA_WIDTH +: DATA_WIDTH]),
                .i_raddr (RAM_AW'({~r_write_bank, w_rd_idx})),
                .o_rdata (w_ram_q[c])
            );
        end
    endgenerate

    // Next-state logic; an arm=0 write overrides everything
    always_comb begin
        w_state_nxt = r_state;
        if (w_arm_clr) begin
            w_state_nxt = IDLE;
        end else begin
            case (r_state)
                IDLE:    if (r_arm) w_state_nxt = ARMED;
                ARMED:   if (w_trigger) w_state_nxt = CAPTURE;
                CAPTURE: begin
                    if (!i_stable) w_state_nxt = ARMED;
                    else if (i_sample_en && r_ptr == IDX_W'(DEPTH - 1)) w_state_nxt = SWAP;
                end
                SWAP:    if (w_swap_done) w_state_nxt = r_arm ? ARMED : IDLE;
                default: w_state_nxt = IDLE;
            endcase
        end
    end

    // State register
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) r_state <= IDLE;
        else          r_state <= w_state_nxt;
    end

    // Capture pointer, bank select, flags and control registers
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_ptr <= '0; r_write_bank <= 1'b0; r_ready <= 1'b0; r_overrun <= 1'b0;
            r_lock <= 1'b0; r_arm <= 1'b0; r_edge <= EDGE_RISE; r_trig_prev <= 1'b0;
        end else begin
            if (w_arm_clr)                       r_ptr <= '0;
            else if (w_trigger)                  r_ptr <= IDX_W'(1);
            else if (r_state == CAPTURE) begin
                if (!i_stable)                   r_ptr <= '0;
                else if (i_sample_en)            r_ptr <= r_ptr + IDX_W'(1);
            end else if (w_swap_done)            r_ptr <= '0;

            if (w_swap_done) r_write_bank <= ~r_write_bank;

            if (w_swap_done)      r_ready <= 1'b1;
            else if (w_lock_rise) r_ready <= 1'b0;

            if ((r_state == SWAP) && i_sample_en)                r_overrun <= 1'b1;
            else if (w_ctrl_wr && i_bus_wdata[CTRL_CLR_OVR_BIT]) r_overrun <= 1'b0;

            if (w_ctrl_wr) begin
                r_lock <= i_bus_wdata[CTRL_LOCK_BIT];
                r_arm  <= i_bus_wdata[CTRL_ARM_BIT];
                r_edge <= edge_mode_e'(i_bus_wdata[CTRL_EDGE_LSB +: 2]);
            end

            if (i_sample_en) r_trig_prev <= i_trig_in;
        end
    end

`ifdef CAP_TIMESTAMP_EN
    logic [31:0] r_ts_cnt, r_ts_trig, r_ts_host;

    // Sample counter, latched at the trigger and published to the host on swap
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_ts_cnt <= '0; r_ts_trig <= '0; r_ts_host <= '0;
        end else begin
            if (i_sample_en) r_ts_cnt  <= r_ts_cnt + 32'd1;
            if (w_trigger)   r_ts_trig <= r_ts_cnt;
            if (w_swap_done) r_ts_host <= r_ts_trig;
        end
    end
`endif

    // Register read mux; unmapped offsets read all-ones
    always_comb begin
        w_reg_rdata = '1;
        case (w_reg_off)
            OFF_W'(REG_STATUS): begin
                w_reg_rdata = '0;
                w_reg_rdata[ST_STATE_LSB +: 2] = r_state;
                w_reg_rdata[ST_LOCK_BIT]       = r_lock;
                w_reg_rdata[ST_OVERRUN_BIT]    = r_overrun;
                w_reg_rdata[ST_READY_BIT]      = r_ready;
            end
            OFF_W'(REG_CTRL): begin
                w_reg_rdata = '0;
                w_reg_rdata[CTRL_LOCK_BIT]      = r_lock;
                w_reg_rdata[CTRL_ARM_BIT]       = r_arm;
                w_reg_rdata[CTRL_EDGE_LSB +: 2] = r_edge;
            end
`ifdef CAP_TIMESTAMP_EN
            OFF_W'(REG_TS_LO): w_reg_rdata = BUS_WIDTH'(r_ts_host[15:0]);
            OFF_W'(REG_TS_HI): w_reg_rdata = BUS_WIDTH'(r_ts_host[31:16]);
`endif
            default: w_reg_rdata = '1;
        endcase
    end

    // Two-stage read pipeline: stage 1 aligns with the RAM read, stage 2 is the output register
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_rd_vld1 <= 1'b0; r_rd_is_reg1 <= 1'b0; r_rd_ch1 <= '0; r_reg_dat1 <= '0;
            r_bus_rvalid <= 1'b0; r_bus_rdata <= '0;
        end else begin
            r_rd_vld1    <= w_rd_take;
            r_rd_is_reg1 <= w_is_reg;
            r_rd_ch1     <= w_rd_ch;
            r_reg_dat1   <= w_reg_rdata;
            r_bus_rvalid <= r_rd_vld1;
            if (r_rd_vld1) begin
                r_bus_rdata <= r_rd_is_reg1 ? r_reg_dat1 : BUS_WIDTH'(w_ram_q[r_rd_ch1]);
            end
        end
    end

    assign o_bus_rdata  = r_bus_rdata;
    assign o_bus_rvalid = r_bus_rvalid;
    assign o_ready      = r_ready;
    assign o_capturing  = (r_state == CAPTURE);

endmodule
